// File: rtl/ro_pkg.sv
// Shared definitions for the RO experiment: FSM encodings and defaults.
// The counter-enable controller takes its state encodings from here too.
package ro_pkg;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_COUNT    = 2'b01;
    localparam logic [1:0] ST_DONE     = 2'b10;
    localparam logic [1:0] ST_WAIT_LOW = 2'b11;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE     = ST_IDLE,
        S_COUNT    = ST_COUNT,
        S_DONE     = ST_DONE,
        S_WAIT_LOW = ST_WAIT_LOW
    } pc_state_e;

endpackage

// File: rtl/ro_pair_counter_if.sv
// Result bus from the pair counter to the readout logic.
// Valid/ready handshake plus the latched window result.
interface ro_pair_counter_if #(
    parameter int CNT_W = 32
);

    logic             result_valid;
    logic             result_ready;
    logic [CNT_W-1:0] count_a;
    logic [CNT_W-1:0] count_b;
    logic             resp_bit;
    logic             overflow;
    logic             window_missed;

    modport master (
        output result_valid,
        output count_a,
        output count_b,
        output resp_bit,
        output overflow,
        output window_missed,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  count_a,
        input  count_b,
        input  resp_bit,
        input  overflow,
        input  window_missed,
        output result_ready
    );

endinterface

// File: rtl/ro_edge_sync.sv
// Synchronizes an asynchronous RO output into clk and emits a
// one-cycle pulse on each synchronized rising edge.
module ro_edge_sync #(
    parameter int SYNC_LEN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ro,
    output logic rise
);

    logic [SYNC_LEN-1:0] sync;
    logic                prev;

    // Synchronizer chain followed by the edge-history flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_LEN-2:0], ro};
            prev <= sync[SYNC_LEN-1];
        end
    end

    assign rise = sync[SYNC_LEN-1] & ~prev;

endmodule

// File: rtl/ro_pair_counter.sv
// Counts rising edges of two ring oscillators over a counteren window
// and hands the latched counts and response bit to readout.
import ro_pkg::*;

module ro_pair_counter #(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int SYNC_LEN = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      counteren,
    input  logic                      ro_a,
    input  logic                      ro_b,
    ro_pair_counter_if.master         res,
    output logic [1:0]                pc_state
);

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    pc_state_e        state;
    pc_state_e        state_nx;
    logic             en_q;
    logic             armed;
    logic             rise;
    logic             fall;
    logic             hs;
    logic             edge_a;
    logic             edge_b;
    logic             ovf;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    ro_edge_sync #(.SYNC_LEN(SYNC_LEN)) u_sync_a (
        .clk  (clk),
        .rst  (rst),
        .ro   (ro_a),
        .rise (edge_a)
    );

    ro_edge_sync #(.SYNC_LEN(SYNC_LEN)) u_sync_b (
        .clk  (clk),
        .rst  (rst),
        .ro   (ro_b),
        .rise (edge_b)
    );

    // armed blocks a window that was already open when rst released
    assign rise = counteren & ~en_q & armed;
    assign fall = ~counteren & en_q;
    assign hs   = res.result_valid & res.result_ready;

    // Next-state logic for the window FSM.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:     if (rise) state_nx = S_COUNT;
            S_COUNT:    if (fall) state_nx = S_DONE;
            S_DONE:     if (hs) state_nx = counteren ? S_WAIT_LOW : S_IDLE;
            S_WAIT_LOW: if (!counteren) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // State register, enable history and the lagging debug copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            en_q     <= 1'b0;
            armed    <= 1'b0;
            pc_state <= ST_IDLE;
        end else begin
            state    <= state_nx;
            en_q     <= counteren;
            armed    <= armed | ~counteren;
            pc_state <= state;
        end
    end

    // Saturating edge counters; ovf marks a counter reaching all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
            ovf   <= 1'b0;
        end else if (state == S_IDLE && rise) begin
            cnt_a <= '0;
            cnt_b <= '0;
            ovf   <= 1'b0;
        end else if (state == S_COUNT && !fall) begin
            if (edge_a && cnt_a != MAX) begin
                cnt_a <= cnt_a + ONE;
                if (cnt_a == MAX - ONE) ovf <= 1'b1;
            end
            if (edge_b && cnt_b != MAX) begin
                cnt_b <= cnt_b + ONE;
                if (cnt_b == MAX - ONE) ovf <= 1'b1;
            end
        end
    end

    // Result latch at window close and handshake bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            res.result_valid  <= 1'b0;
            res.count_a       <= '0;
            res.count_b       <= '0;
            res.resp_bit      <= 1'b0;
            res.overflow      <= 1'b0;
            res.window_missed <= 1'b0;
        end else if (state == S_COUNT && fall) begin
            res.result_valid <= 1'b1;
            res.count_a      <= cnt_a;
            res.count_b      <= cnt_b;
            res.resp_bit     <= cnt_a > cnt_b;
            res.overflow     <= ovf;
        end else if (state == S_DONE) begin
            if (hs) begin
                res.result_valid  <= 1'b0;
                res.window_missed <= 1'b0;
            end else if (rise) begin
                res.window_missed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ro_pair_counter.sv
// Scoreboard bench for ro_pair_counter: directed windows push expected
// results; a negedge monitor pops and compares on each handshake.
module tb_ro_pair_counter;

    typedef struct {
        int a_lo;
        int a_hi;
        int b_lo;
        int b_hi;
        bit resp;
        bit ovf;
        bit missed;
        bit chk_missed;
        bit tie;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       counteren;
    logic       ro_a;
    logic       ro_b;
    logic [1:0] pc_state;
    logic       counteren_s;
    logic       ro_a_s;
    logic       ro_b_s;
    logic [1:0] pc_state_s;

    int   checks;
    int   errors;
    exp_t q[$];
    exp_t qs[$];

    ro_pair_counter_if #(.CNT_W(32)) bus ();
    ro_pair_counter_if #(.CNT_W(4))  bus_s ();

    ro_pair_counter #(.CNT_W(32), .SYNC_LEN(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .counteren (counteren),
        .ro_a      (ro_a),
        .ro_b      (ro_b),
        .res       (bus.master),
        .pc_state  (pc_state)
    );

    ro_pair_counter #(.CNT_W(4), .SYNC_LEN(2)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .counteren (counteren_s),
        .ro_a      (ro_a_s),
        .ro_b      (ro_b_s),
        .res       (bus_s.master),
        .pc_state  (pc_state_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input longint act,
                       input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic en,
                         input logic a, input logic b);
        if (s) begin
            counteren_s = en;
            ro_a_s      = a;
            ro_b_s      = b;
        end else begin
            counteren   = en;
            ro_a        = a;
            ro_b        = b;
        end
    endtask

    // Open a window for n cycles; returns in the close cycle.
    task automatic window(input bit s, input int n, input int pa,
                          input int pb, input int nb);
        for (int i = 0; i < n; i++) begin
            drive(s, 1'b1, (i % pa) < pa / 2,
                  ((i % pb) < pb / 2) && (i < nb));
            tick();
        end
        drive(s, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic exp_t mk(input int alo, input int ahi,
                                input int blo, input int bhi,
                                input bit r, input bit o,
                                input bit m, input bit cm,
                                input bit t);
        exp_t e;
        e.a_lo = alo; e.a_hi = ahi;
        e.b_lo = blo; e.b_hi = bhi;
        e.resp = r;   e.ovf = o;
        e.missed = m; e.chk_missed = cm;
        e.tie = t;
        return e;
    endfunction

    // Monitor: every accepted result is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.result_valid && bus.result_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: count_a=%0d count_b=%0d",
                         bus.count_a, bus.count_b);
            end else begin
                e = q.pop_front();
                chk("count_a", bus.count_a, e.a_lo, e.a_hi);
                chk("count_b", bus.count_b, e.b_lo, e.b_hi);
                chk("resp_bit", bus.resp_bit, e.resp, e.resp);
                chk("overflow", bus.overflow, e.ovf, e.ovf);
                if (e.chk_missed)
                    chk("window_missed", bus.window_missed,
                        e.missed, e.missed);
                if (e.tie)
                    chk("tie_equal", bus.count_a == bus.count_b, 1, 1);
            end
        end
        if (bus_s.result_valid && bus_s.result_ready) begin
            if (qs.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result_s: count_a=%0d",
                         bus_s.count_a);
            end else begin
                e = qs.pop_front();
                chk("sat_count_a", bus_s.count_a, e.a_lo, e.a_hi);
                chk("sat_count_b", bus_s.count_b, e.b_lo, e.b_hi);
                chk("sat_resp", bus_s.resp_bit, e.resp, e.resp);
                chk("sat_overflow", bus_s.overflow, e.ovf, e.ovf);
            end
        end
    end

    initial begin
        bit bad;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        bus.result_ready   = 1'b1;
        bus_s.result_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cnt", bus.count_a | bus.count_b, 0, 0);
        chk("reset_flags", {bus.result_valid, bus.resp_bit, bus.overflow,
                            bus.window_missed, pc_state}, 0, 0);
        chk("reset_s", {bus_s.result_valid, bus_s.count_a, pc_state_s},
            0, 0);
        repeat (3) tick();

        // Basic window with a single-cycle valid pulse.
        q.push_back(mk(29, 31, 19, 21, 1, 0, 0, 1, 0));
        window(0, 240, 8, 12, 240);
        @(negedge clk);
        chk("valid_close_cycle", bus.result_valid, 0, 0);
        tick();
        @(negedge clk);
        chk("valid_rise", bus.result_valid, 1, 1);
        tick();
        @(negedge clk);
        chk("valid_pulse_end", bus.result_valid, 0, 0);
        repeat (3) tick();

        // Saturation on the 4-bit instance.
        qs.push_back(mk(15, 15, 3, 3, 1, 1, 0, 1, 0));
        window(1, 320, 8, 8, 24);
        repeat (4) tick();

        // Backpressure with a second window opened while pending.
        bus.result_ready = 1'b0;
        q.push_back(mk(12, 12, 8, 8, 1, 0, 1, 1, 0));
        window(0, 96, 8, 12, 96);
        tick();
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            drive(0, (i >= 10 && i < 30), (i % 8) < 4, (i % 12) < 6);
            @(negedge clk);
            if (!bus.result_valid || bus.count_a != 12 ||
                bus.count_b != 8 || !bus.resp_bit || bus.overflow)
                bad = 1'b1;
            tick();
        end
        drive(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_stable", bad, 0, 0);
        chk("bp_missed_set", bus.window_missed, 1, 1);
        tick();
        bus.result_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_missed_clear", bus.window_missed, 0, 0);
        chk("bp_valid_clear", bus.result_valid, 0, 0);
        repeat (3) tick();

        // Enable still high at the handshake parks the FSM in WAIT_LOW.
        q.push_back(mk(6, 6, 4, 4, 1, 0, 0, 0, 0));
        window(0, 48, 8, 12, 48);
        tick();
        drive(0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        chk("held_wait_low", pc_state, 3, 3);
        for (int i = 0; i < 30; i++) begin
            drive(0, 1'b1, (i % 8) < 4, (i % 12) < 6);
            tick();
        end
        @(negedge clk);
        chk("held_still_wait", pc_state, 3, 3);
        drive(0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        chk("held_back_idle", pc_state, 0, 0);

        // Tie: identical RO inputs after WAIT_LOW released.
        q.push_back(mk(12, 14, 12, 14, 0, 0, 0, 1, 1));
        window(0, 100, 8, 8, 100);
        repeat (4) tick();

        // Reset in mid-window discards everything.
        for (int i = 0; i < 200; i++) begin
            drive(0, 1'b1, (i % 8) < 4, (i % 12) < 6);
            rst = (i == 60);
            @(negedge clk);
            if (i == 61) begin
                chk("midrst_cnt", bus.count_a | bus.count_b, 0, 0);
                chk("midrst_flags", {bus.result_valid, bus.resp_bit,
                    bus.overflow, bus.window_missed, pc_state}, 0, 0);
            end
            if (i == 150)
                chk("midrst_idle", pc_state, 0, 0);
            tick();
        end
        drive(0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        @(negedge clk);
        chk("midrst_no_valid", bus.result_valid, 0, 0);

        // Fresh window after reset counts normally.
        q.push_back(mk(6, 6, 4, 4, 1, 0, 0, 1, 0));
        window(0, 48, 8, 12, 48);

        for (int k = 0; k < 100 && (q.size() > 0 || qs.size() > 0); k++)
            tick();
        checks++;
        if (q.size() > 0 || qs.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, want 0",
                     q.size() + qs.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
